prog_loader: RTL and testbench

Program-memory loader for the 4-stage core. It accepts a stream of instruction words over a valid/ready handshake and drives the program memory's write port (W, ADDR, DATA_WR) at consecutive addresses starting at 0. While it runs, `busy` holds the core off and steers the memory address mux to the write address. It reports completion, errors and a running XOR checksum of the loaded image.

---
 rtl/prog_loader.sv | 169 ++++++++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: streams instruction words into consecutive addresses,
// holding the core off via busy and reporting done/err plus an XOR checksum.
module prog_loader #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   len,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 W,
  output logic [ADDR_SIZE-1:0] ADDR,
  output logic [DATA_SIZE-1:0] DATA_WR,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATA_SIZE-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE:0]   CNT_ZERO = {(ADDR_SIZE+1){1'b0}};
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   MAX_LEN  = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [7:0]           TMO_ZERO = 8'd0;
  localparam logic [7:0]           TMO_ONE  = 8'd1;
  localparam logic [7:0]           TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_SIZE-1:0] DAT_ZERO = {DATA_SIZE{1'b0}};
  localparam logic [ADDR_SIZE-1:0] ADR_ZERO = {ADDR_SIZE{1'b0}};

  function automatic logic [DATA_SIZE-1:0] cs_update(input logic [DATA_SIZE-1:0] cs,
                                                     input logic [DATA_SIZE-1:0] word);
    return cs ^ word;
  endfunction

  state_t               state_r, state_s;
  logic [ADDR_SIZE:0]   len_r, len_s;
  logic [ADDR_SIZE:0]   cnt_r, cnt_s;
  logic [7:0]           tmo_r, tmo_s;
  logic                 in_ready_r, in_ready_s;
  logic                 w_r, w_s;
  logic [ADDR_SIZE-1:0] addr_r, addr_s;
  logic [DATA_SIZE-1:0] data_r, data_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 err_r, err_s;
  logic [DATA_SIZE-1:0] cs_r, cs_s;
  logic                 accept_s;
  logic                 len_ok_s;

  assign accept_s = in_valid & in_ready_r;
  assign len_ok_s = (len != CNT_ZERO) && (len <= MAX_LEN);

  // Next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    cnt_s      = cnt_r;
    tmo_s      = tmo_r;
    in_ready_s = in_ready_r;
    w_s        = 1'b0;
    addr_s     = addr_r;
    data_s     = data_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    cs_s       = cs_r;
    case (state_r)
      IDLE: begin
        if (start && len_ok_s) begin
          state_s    = LOAD;
          len_s      = len;
          cnt_s      = CNT_ZERO;
          tmo_s      = TMO_ZERO;
          cs_s       = DAT_ZERO;
          busy_s     = 1'b1;
          in_ready_s = 1'b1;
        end else if (start) begin
          err_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          w_s    = 1'b1;
          addr_s = cnt_r[ADDR_SIZE-1:0];
          data_s = in_data;
          cs_s   = cs_update(cs_r, in_data);
          cnt_s  = cnt_r + CNT_ONE;
          tmo_s  = TMO_ZERO;
          // in_ready must already be low while the final write sits in DONE
          if ((cnt_r + CNT_ONE) == len_r) begin
            state_s    = DONE;
            in_ready_s = 1'b0;
          end else begin
            state_s = LOAD;
          end
        end else if (tmo_r == TMO_LAST) begin
          state_s    = IDLE;
          err_s      = 1'b1;
          busy_s     = 1'b0;
          in_ready_s = 1'b0;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
        done_s  = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        state_s    = IDLE;
        busy_s     = 1'b0;
        in_ready_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      len_r      <= CNT_ZERO;
      cnt_r      <= CNT_ZERO;
      tmo_r      <= TMO_ZERO;
      in_ready_r <= 1'b0;
      w_r        <= 1'b0;
      addr_r     <= ADR_ZERO;
      data_r     <= DAT_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cs_r       <= DAT_ZERO;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      cnt_r      <= cnt_s;
      tmo_r      <= tmo_s;
      in_ready_r <= in_ready_s;
      w_r        <= w_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      cs_r       <= cs_s;
    end
  end

  assign in_ready = in_ready_r;
  assign W        = w_r;
  assign ADDR     = addr_r;
  assign DATA_WR  = data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign checksum = cs_r;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: the driver predicts every
// write/done/err event with its cycle stamp; a monitor pops and compares.
module tb_prog_loader;

  localparam int TMO = 8;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [5:0] len;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       W;
  logic [4:0] ADDR;
  logic [5:0] DATA_WR;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] checksum;

  prog_loader #(.DATA_SIZE(6), .ADDR_SIZE(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .W(W), .ADDR(ADDR), .DATA_WR(DATA_WR), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  typedef struct {
    int         kind;   // 0 write, 1 done, 2 err
    int         cyc;
    int         addr;
    logic [5:0] data;   // write data, or checksum expected with done/err
  } ev_t;

  ev_t        q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [5:0] cs_last = 6'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic chk_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    if (q.size() == 0 || q[0].kind != kind) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event kind %0d at cycle %0d: got event, expected none", kind, cyc);
    end else begin
      check("event_cycle", cyc, q[0].cyc);
      if (kind == 0) check("write_addr", a, q[0].addr);
      check("event_data", d, {26'd0, q[0].data});
      void'(q.pop_front());
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard queue
  always @(negedge clk) begin
    if (rstn) begin
      if (W)    chk_ev(0, {27'd0, ADDR}, {26'd0, DATA_WR});
      if (done) chk_ev(1, 32'd0, {26'd0, checksum});
      if (err)  chk_ev(2, 32'd0, {26'd0, checksum});
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_event kind %0d: got nothing by cycle %0d, expected at %0d",
                 q[0].kind, cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // Issues a start at the current negedge; sends up to stop_after words.
  // mode: 0 back-to-back random, 1 alternate valid, 2 random gaps, 3 walking-one data
  task automatic run_load(input int n, input int stop_after, input int mode);
    int         sent;
    int         idle;
    bit         ph;
    bit         go;
    logic [5:0] w;
    sent    = 0;
    idle    = 0;
    ph      = 1'b0;
    start   = 1'b1;
    len     = 6'(n);
    cs_last = 6'd0;
    @(negedge clk);
    forever begin
      check("in_ready_load", {31'd0, in_ready}, 32'd1);
      check("busy_load", {31'd0, busy}, 32'd1);
      start = 1'($urandom_range(1));
      len   = 6'($urandom);
      case (mode)
        1:       go = !ph;
        2:       go = ($urandom_range(99) >= 30);
        default: go = 1'b1;
      endcase
      ph = !ph;
      if (sent < stop_after && go) begin
        w        = (mode == 3) ? 6'(1 << sent) : 6'($urandom);
        in_valid = 1'b1;
        in_data  = w;
        q.push_back('{0, cyc + 1, sent, w});
        cs_last ^= w;
        sent++;
        idle = 0;
        if (sent == n) begin
          q.push_back('{1, cyc + 2, 0, cs_last});
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = 6'($urandom);
          check("in_ready_done_state", {31'd0, in_ready}, 32'd0);
          check("busy_done_state", {31'd0, busy}, 32'd1);
          @(negedge clk);
          start    = 1'b0;
          in_valid = 1'b0;
          check("busy_after_done", {31'd0, busy}, 32'd0);
          check("in_ready_after_done", {31'd0, in_ready}, 32'd0);
          break;
        end
      end else begin
        in_valid = 1'b0;
        in_data  = 6'($urandom);
        idle++;
        if (idle == TMO) begin
          q.push_back('{2, cyc + 1, 0, cs_last});
          @(negedge clk);
          start = 1'b0;
          check("busy_after_timeout", {31'd0, busy}, 32'd0);
          check("in_ready_after_timeout", {31'd0, in_ready}, 32'd0);
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic bad_start(input int n);
    start = 1'b1;
    len   = 6'(n);
    q.push_back('{2, cyc + 1, 0, cs_last});
    @(negedge clk);
    start = 1'b0;
    check("busy_bad_len", {31'd0, busy}, 32'd0);
    check("in_ready_bad_len", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] w;
    int         n;
    rstn     = 1'b0;
    start    = 1'b0;
    len      = 6'd0;
    in_valid = 1'b0;
    in_data  = 6'd0;
    repeat (4) begin
      @(negedge clk);
      start    = 1'($urandom_range(1));
      len      = 6'($urandom);
      in_valid = 1'($urandom_range(1));
      in_data  = 6'($urandom);
      check("reset_outputs", {10'd0, in_ready, W, ADDR, DATA_WR, busy, done, err, checksum}, 32'd0);
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #2 rstn  = 1'b1;
    @(negedge clk);
    check("busy_post_reset", {31'd0, busy}, 32'd0);
    check("in_ready_post_reset", {31'd0, in_ready}, 32'd0);

    run_load(4, 4, 3);
    check("basic_checksum", {26'd0, checksum}, 32'h0F);
    run_load(32, 32, 1);
    @(negedge clk);
    bad_start(0);
    bad_start(33);
    run_load(3, 1, 0);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(32, 1);
      if ($urandom_range(3) == 0) run_load(n, $urandom_range(n - 1), 2);
      else                        run_load(n, n, 2);
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    // abort a load with reset after two accepts
    @(negedge clk);
    start   = 1'b1;
    len     = 6'd5;
    cs_last = 6'd0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    w        = 6'($urandom);
    in_data  = w;
    q.push_back('{0, cyc + 1, 0, w});
    @(negedge clk);
    w       = 6'($urandom);
    in_data = w;
    q.push_back('{0, cyc + 1, 1, w});
    @(negedge clk);
    in_valid = 1'b0;
    #2 rstn  = 1'b0;
    #1 check("reset_mid_load", {10'd0, in_ready, W, ADDR, DATA_WR, busy, done, err, checksum}, 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    run_load(1, 1, 0);
    check("reload_checksum", {26'd0, checksum}, {26'd0, cs_last});

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish before 300000");
    $fatal(1, "watchdog");
  end

endmodule
